// File: rtl/motion_seq.sv
// motion_seq: multi-channel encoder-counted move sequencer.
// One start launches every channel with a nonzero target. Each channel runs
// until it has counted its encoder edges or its bump stop fires. A move ends
// with a one-cycle done pulse, or silently on abort or reset.
module motion_seq #(
    parameter int NCH   = 2,
    parameter int CNT_W = 16,
    parameter int PWM_W = 10
) (
    input  logic                 WF_CLK,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [NCH*CNT_W-1:0] target,
    input  logic [NCH*PWM_W-1:0] duty,
    input  logic [NCH-1:0]       dir_in,
    input  logic [NCH-1:0]       encdr,
    input  logic [NCH-1:0]       stop_req,
    output logic [NCH-1:0]       pwm,
    output logic [NCH-1:0]       en,
    output logic [NCH-1:0]       dir,
    output logic [NCH*CNT_W-1:0] count,
    output logic                 busy,
    output logic                 done,
    output logic [NCH-1:0]       fault,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PWM_W-1:0] PC_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state;
    logic [NCH-1:0]       run;
    logic [NCH*CNT_W-1:0] tgt_sh;
    logic [NCH*PWM_W-1:0] duty_sh;
    logic [PWM_W-1:0]     pc;
    logic [NCH-1:0]       enc_s1, enc_s2, enc_s3;
    logic [NCH-1:0]       stp_s1, stp_s2;
    logic [NCH-1:0]       enc_edge;
    logic                 accept;

    // A start counts only when idle, and abort always beats it.
    assign accept    = (state == IDLE) && start && !abort;
    assign enc_edge  = enc_s2 & ~enc_s3;
    assign en        = run;
    assign fsm_state = state;

    // Sequencer: IDLE -> RUN on accepted start, RUN -> FIN when every channel stops.
    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (run == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Per-channel datapath: synchronisers, shadows, counting, stop and PWM.
    always_ff @(posedge WF_CLK) begin
        if (rst) begin
            enc_s1  <= '0;
            enc_s2  <= '0;
            enc_s3  <= '0;
            stp_s1  <= '0;
            stp_s2  <= '0;
            pc      <= '0;
            run     <= '0;
            pwm     <= '0;
            dir     <= '0;
            count   <= '0;
            fault   <= '0;
            tgt_sh  <= '0;
            duty_sh <= '0;
        end else begin
            enc_s1 <= encdr;
            enc_s2 <= enc_s1;
            enc_s3 <= enc_s2;
            stp_s1 <= stop_req;
            stp_s2 <= stp_s1;
            pc     <= pc + PC_ONE;
            if (accept) begin
                tgt_sh  <= target;
                duty_sh <= duty;
                dir     <= dir_in;
                count   <= '0;
                fault   <= '0;
                for (int i = 0; i < NCH; i++)
                    run[i] <= (target[i*CNT_W +: CNT_W] != '0);
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    if (abort) begin
                        run[i] <= 1'b0;
                    end else if (run[i]) begin
                        // Edge and stop may coincide: the edge still counts.
                        if (enc_edge[i] && count[i*CNT_W +: CNT_W] != CNT_MAX) begin
                            count[i*CNT_W +: CNT_W] <= count[i*CNT_W +: CNT_W] + CNT_ONE;
                            if (count[i*CNT_W +: CNT_W] + CNT_ONE == tgt_sh[i*CNT_W +: CNT_W])
                                run[i] <= 1'b0;
                        end
                        if (stp_s2[i]) begin
                            run[i]   <= 1'b0;
                            fault[i] <= 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < NCH; i++)
                pwm[i] <= run[i] && (pc < duty_sh[i*PWM_W +: PWM_W]);
        end
    end

endmodule

// File: tb/tb_motion_seq.sv
// tb_motion_seq: directed bench for motion_seq with NCH=2, CNT_W=16, PWM_W=10.
// Expected values are queued as each step is driven and popped when the DUT
// output is sampled on the falling edge.
module tb_motion_seq;

    logic        WF_CLK = 1'b0;
    logic        rst, start, abort;
    logic [31:0] target;
    logic [19:0] duty;
    logic [1:0]  dir_in, encdr, stop_req;
    logic [1:0]  pwm, en, dir, fault;
    logic [31:0] count;
    logic        busy, done;
    logic [1:0]  fsm_state;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_seen = 0;

    motion_seq #(.NCH(2), .CNT_W(16), .PWM_W(10)) dut (
        .WF_CLK(WF_CLK), .rst(rst), .start(start), .abort(abort),
        .target(target), .duty(duty), .dir_in(dir_in), .encdr(encdr),
        .stop_req(stop_req), .pwm(pwm), .en(en), .dir(dir), .count(count),
        .busy(busy), .done(done), .fault(fault), .fsm_state(fsm_state)
    );

    // clock
    always #5 WF_CLK = ~WF_CLK;

    // count done pulses, sampled away from the active edge
    always @(negedge WF_CLK) if (done) done_seen++;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%0h but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge WF_CLK);
    endtask

    task automatic start_move(input logic [15:0] t1, input logic [15:0] t0,
                              input logic [9:0] d1, input logic [9:0] d0,
                              input logic [1:0] dv);
        target = {t1, t0};
        duty   = {d1, d0};
        dir_in = dv;
        start  = 1'b1;
        @(negedge WF_CLK);
        start  = 1'b0;
    endtask

    // one encoder pulse: 3 cycles high, 3 cycles low
    task automatic pulse(input logic [1:0] mask);
        encdr = mask;
        cycles(3);
        encdr = 2'b00;
        cycles(3);
    endtask

    initial begin
        int c0, c1, h0, h1;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        target = '0; duty = '0; dir_in = '0; encdr = '0; stop_req = '0;
        cycles(3);
        rst = 1'b0;
        cycles(1);

        // reset state
        push(32'd0); chk("rst_busy", busy);
        push(32'd0); chk("rst_en", en);
        push(32'd0); chk("rst_count", count);
        push(32'd0); chk("rst_fault", fault);

        // normal move, targets ch1=3 ch0=5
        done_seen = 0;
        start_move(16'd3, 16'd5, 10'd512, 10'd512, 2'b10);
        push(32'd3); chk("start_en", en);
        push(32'd1); chk("start_busy", busy);
        push(32'd2); chk("start_dir", dir);
        for (int k = 1; k <= 5; k++) begin
            pulse(2'b11);
            c0 = (k < 5) ? k : 5;
            c1 = (k < 3) ? k : 3;
            push((32'(c1) << 16) | 32'(c0)); chk("move_count", count);
            push({30'd0, (k < 3), (k < 5)}); chk("move_en", en);
        end
        cycles(4);
        push(32'd1); chk("move_done_once", 32'(done_seen));
        push(32'd0); chk("move_busy_end", busy);
        pulse(2'b11);
        pulse(2'b11);
        push((32'd3 << 16) | 32'd5); chk("extra_edges_count", count);
        push(32'd2); chk("dir_held", dir);

        // bump stop on ch0 after 10 edges
        done_seen = 0;
        start_move(16'd20, 16'd100, 10'd512, 10'd512, 2'b00);
        for (int k = 0; k < 10; k++) pulse(2'b11);
        push((32'd10 << 16) | 32'd10); chk("bump_pre_count", count);
        stop_req = 2'b01;
        cycles(3);
        push(32'd2); chk("bump_en", en);
        push(32'd1); chk("bump_fault", fault);
        push(32'd1); chk("bump_busy", busy);
        stop_req = 2'b00;
        for (int k = 0; k < 10; k++) pulse(2'b10);
        cycles(4);
        push(32'd1); chk("bump_done", 32'(done_seen));
        push((32'd20 << 16) | 32'd10); chk("bump_count", count);
        push(32'd1); chk("bump_fault_held", fault);

        // start while running is ignored
        done_seen = 0;
        start_move(16'd2, 16'd2, 10'd100, 10'd100, 2'b01);
        pulse(2'b11);
        start_move(16'd9, 16'd9, 10'd100, 10'd100, 2'b10);
        push(32'd1); chk("ignored_start_dir", dir);
        push(32'd0); chk("ignored_start_fault", fault);
        pulse(2'b11);
        pulse(2'b11);
        cycles(3);
        push((32'd2 << 16) | 32'd2); chk("ignored_start_count", count);
        push(32'd1); chk("ignored_start_done", 32'(done_seen));

        // abort mid-move
        start_move(16'd50, 16'd50, 10'd100, 10'd100, 2'b11);
        for (int k = 0; k < 3; k++) pulse(2'b11);
        done_seen = 0;
        abort = 1'b1;
        @(negedge WF_CLK);
        abort = 1'b0;
        push(32'd0); chk("abort_busy", busy);
        push(32'd0); chk("abort_en", en);
        push((32'd3 << 16) | 32'd3); chk("abort_count", count);
        cycles(6);
        push(32'd0); chk("abort_no_done", 32'(done_seen));

        // abort and start together: no move
        target = {16'd4, 16'd4};
        start = 1'b1; abort = 1'b1;
        @(negedge WF_CLK);
        start = 1'b0; abort = 1'b0;
        push(32'd0); chk("abort_start_busy", busy);
        push(32'd0); chk("abort_start_en", en);

        // all-zero targets: done two cycles after start
        done_seen = 0;
        target = '0;
        start = 1'b1;
        @(negedge WF_CLK);
        start = 1'b0;
        push(32'd0); chk("zero_done_c1", done);
        push(32'd0); chk("zero_en_c1", en);
        push(32'd1); chk("zero_busy_c1", busy);
        @(negedge WF_CLK);
        push(32'd1); chk("zero_done_c2", done);
        push(32'd0); chk("zero_en_c2", en);
        @(negedge WF_CLK);
        push(32'd0); chk("zero_done_c3", done);
        push(32'd0); chk("zero_busy_c3", busy);
        push(32'd1); chk("zero_done_once", 32'(done_seen));

        // PWM duty over one full period
        start_move(16'd1000, 16'd1000, 10'd0, 10'd256, 2'b00);
        cycles(2);
        h0 = 0; h1 = 0;
        for (int k = 0; k < 1024; k++) begin
            if (pwm[0]) h0++;
            if (pwm[1]) h1++;
            @(negedge WF_CLK);
        end
        push(32'd256); chk("pwm_duty256", 32'(h0));
        push(32'd0); chk("pwm_duty0", 32'(h1));
        abort = 1'b1;
        @(negedge WF_CLK);
        abort = 1'b0;
        cycles(2);
        push(32'd0); chk("pwm_after_abort", pwm);

        // reset mid-move, then a normal move
        done_seen = 0;
        start_move(16'd50, 16'd50, 10'd512, 10'd512, 2'b11);
        pulse(2'b11);
        pulse(2'b11);
        rst = 1'b1;
        @(negedge WF_CLK);
        push(32'd0); chk("rst_mid_en", en);
        push(32'd0); chk("rst_mid_busy", busy);
        push(32'd0); chk("rst_mid_count", count);
        push(32'd0); chk("rst_mid_dir", dir);
        push(32'd0); chk("rst_mid_pwm", pwm);
        push(32'd0); chk("rst_mid_done", done);
        rst = 1'b0;
        cycles(2);
        push(32'd0); chk("rst_mid_no_done", 32'(done_seen));
        start_move(16'd1, 16'd1, 10'd512, 10'd512, 2'b01);
        push(32'd3); chk("post_rst_en", en);
        pulse(2'b11);
        cycles(3);
        push(32'd1); chk("post_rst_done", 32'(done_seen));
        push((32'd1 << 16) | 32'd1); chk("post_rst_count", count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
